// File: rtl/sme_job_sched.sv
// ============================================================================
// sme_job_sched : buffers one string plus up to NPAT patterns, replays them to
// the matching engine and returns one tagged result per pattern.
// Revision 1.0
// ============================================================================
`default_nettype none

module sme_job_sched #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int NPAT    = 4,
    parameter int TMO     = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic                        wr_last,
    input  logic [7:0]                  wr_data,
    input  logic                        start,
    output logic                        busy,
    output logic [7:0]                  sme_chardata,
    output logic                        sme_isstring,
    output logic                        sme_ispattern,
    input  logic                        sme_match,
    input  logic [$clog2(STR_MAX)-1:0]  sme_match_index,
    input  logic                        sme_valid,
    output logic                        res_valid,
    output logic                        res_match,
    output logic [$clog2(STR_MAX)-1:0]  res_index,
    output logic [$clog2(NPAT)-1:0]     res_id,
    output logic                        res_timeout,
    output logic                        done,
    output logic                        ovf
);
    localparam int SIW = $clog2(STR_MAX);
    localparam int SLW = SIW + 1;
    localparam int PIW = $clog2(PAT_MAX);
    localparam int PLW = PIW + 1;
    localparam int IDW = $clog2(NPAT);
    localparam int PCW = IDW + 1;
    localparam int TW  = $clog2(TMO + 1);

    localparam logic [SLW-1:0] C_STR_MAX  = SLW'(STR_MAX);
    localparam logic [PLW-1:0] C_PAT_MAX  = PLW'(PAT_MAX);
    localparam logic [PCW-1:0] C_NPAT     = PCW'(NPAT);
    localparam logic [TW-1:0]  C_TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STR  = 3'd1,
        S_PAT  = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [7:0]     str_buf [STR_MAX];
    logic [7:0]     pat_buf [NPAT][PAT_MAX];
    logic [PLW-1:0] plen    [NPAT];
    logic [SLW-1:0] str_len;
    logic [PCW-1:0] pat_cnt;
    logic [SIW-1:0] sidx;
    logic [PIW-1:0] pidx;
    logic [IDW-1:0] pat;
    logic [TW-1:0]  timer;
    logic           ovf_flag;
    logic           rmatch;
    logic [SIW-1:0] rindex;
    logic           rtimeout;

    logic           in_idle, slot_avail;
    logic [IDW-1:0] wslot;
    logic [PLW-1:0] wslot_len, cur_len;
    logic           wr_str_ok, wr_str_drop, wr_pat_ok, wr_pat_drop, pat_close;
    logic [SLW-1:0] str_len_upd;
    logic [PCW-1:0] pat_cnt_upd;
    logic           str_last, pat_char_last, job_last, tmo_hit;

    assign in_idle    = (state == S_IDLE);
    assign wslot      = pat_cnt[IDW-1:0];
    assign slot_avail = (pat_cnt != C_NPAT);
    assign wslot_len  = plen[wslot];
    assign cur_len    = plen[pat];

    assign wr_str_ok   = in_idle && wr_en && !wr_sel && (str_len != C_STR_MAX);
    assign wr_str_drop = in_idle && wr_en && !wr_sel && (str_len == C_STR_MAX);
    assign wr_pat_ok   = in_idle && wr_en && wr_sel && slot_avail && (wslot_len != C_PAT_MAX);
    assign wr_pat_drop = in_idle && wr_en && wr_sel && !wr_pat_ok;
    // A slot closes on wr_last even when its final char was dropped for length.
    assign pat_close   = in_idle && wr_en && wr_sel && wr_last && slot_avail;

    assign str_len_upd = str_len + SLW'(wr_str_ok);
    assign pat_cnt_upd = pat_cnt + PCW'(pat_close);

    assign str_last      = ({1'b0, sidx} == (str_len - SLW'(1)));
    assign pat_char_last = ({1'b0, pidx} == (cur_len - PLW'(1)));
    assign job_last      = ({1'b0, pat} == (pat_cnt - PCW'(1)));
    assign tmo_hit       = (timer == C_TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        sme_chardata  = 8'd0;
        sme_isstring  = 1'b0;
        sme_ispattern = 1'b0;
        res_valid     = 1'b0;
        res_match     = 1'b0;
        res_index     = '0;
        res_id        = '0;
        res_timeout   = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (str_len_upd == '0 || pat_cnt_upd == '0) state_nxt = S_FIN;
                    else                                         state_nxt = S_STR;
                end
            end
            S_STR: begin
                busy         = 1'b1;
                sme_chardata = str_buf[sidx];
                sme_isstring = 1'b1;
                if (str_last) state_nxt = S_PAT;
            end
            S_PAT: begin
                busy = 1'b1;
                if (cur_len == '0) begin
                    state_nxt = S_RES;
                end else begin
                    sme_chardata  = pat_buf[pat][pidx];
                    sme_ispattern = 1'b1;
                    if (pat_char_last) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (sme_valid || tmo_hit) state_nxt = S_RES;
            end
            S_RES: begin
                busy        = 1'b1;
                res_valid   = 1'b1;
                res_match   = rmatch;
                res_index   = rindex;
                res_id      = pat;
                res_timeout = rtimeout;
                state_nxt   = job_last ? S_FIN : S_PAT;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ovf = ovf_flag;

    // Buffers hold no reset: their contents are only read below the valid lengths.
    always_ff @(posedge clk) begin
        if (wr_str_ok) str_buf[str_len[SIW-1:0]] <= wr_data;
        if (wr_pat_ok) pat_buf[wslot][wslot_len[PIW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_len  <= '0;
            pat_cnt  <= '0;
            for (int k = 0; k < NPAT; k++) plen[k] <= '0;
            sidx     <= '0;
            pidx     <= '0;
            pat      <= '0;
            timer    <= '0;
            ovf_flag <= 1'b0;
            rmatch   <= 1'b0;
            rindex   <= '0;
            rtimeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    str_len <= str_len_upd;
                    pat_cnt <= pat_cnt_upd;
                    if (wr_pat_ok) plen[wslot] <= wslot_len + PLW'(1);
                    if (wr_str_drop || wr_pat_drop) ovf_flag <= 1'b1;
                    if (start) begin
                        ovf_flag <= 1'b0;
                        sidx     <= '0;
                    end
                end
                S_STR: begin
                    sidx <= sidx + SIW'(1);
                    if (str_last) begin
                        pat  <= '0;
                        pidx <= '0;
                    end
                end
                S_PAT: begin
                    pidx <= pidx + PIW'(1);
                    if (cur_len == '0) begin
                        rmatch   <= 1'b0;
                        rindex   <= '0;
                        rtimeout <= 1'b1;
                    end else if (pat_char_last) begin
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (sme_valid) begin
                        rmatch   <= sme_match;
                        rindex   <= sme_match_index;
                        rtimeout <= 1'b0;
                    end else if (tmo_hit) begin
                        rmatch   <= 1'b0;
                        rindex   <= '0;
                        rtimeout <= 1'b1;
                    end
                end
                S_RES: begin
                    if (!job_last) begin
                        pat  <= pat + IDW'(1);
                        pidx <= '0;
                    end
                end
                S_FIN: begin
                    str_len <= '0;
                    pat_cnt <= '0;
                    for (int k = 0; k < NPAT; k++) plen[k] <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sme_job_sched.sv
// ============================================================================
// tb_sme_job_sched : directed self-checking bench for sme_job_sched.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sme_job_sched;
    localparam int TMO = 255;

    logic       clk, reset;
    logic       wr_en, wr_sel, wr_last, start;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] sme_chardata;
    logic       sme_isstring, sme_ispattern;
    logic       sme_match, sme_valid;
    logic [4:0] sme_match_index;
    logic       res_valid, res_match, res_timeout, done, ovf;
    logic [4:0] res_index;
    logic [1:0] res_id;

    int vectors = 0;
    int errs    = 0;

    sme_job_sched #(.STR_MAX(32), .PAT_MAX(8), .NPAT(4), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_last(wr_last), .wr_data(wr_data),
        .start(start), .busy(busy),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
        .sme_match(sme_match), .sme_match_index(sme_match_index), .sme_valid(sme_valid),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_id(res_id), .res_timeout(res_timeout), .done(done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(input string s);
        for (int k = 0; k < s.len(); k++) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_last = 1'b0; wr_data = s[k];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic load_pat(input string s);
        for (int k = 0; k < s.len(); k++) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_last = (k == s.len() - 1); wr_data = s[k];
            tick();
        end
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  n, nstr, npat;
        logic [7:0] lastp;
        logic tmo_seen, saw_done;
        string pats;

        reset = 1'b0; wr_en = 0; wr_sel = 0; wr_last = 0; wr_data = 0; start = 0;
        sme_match = 0; sme_match_index = 0; sme_valid = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {sme_chardata, sme_isstring, sme_ispattern, res_valid, res_match,
                         res_index, res_id, res_timeout, done, ovf}, 0);
        reset = 1'b1;
        tick();

        // Basic job: "ABCDE" with patterns "CD" and "X"
        load_str("ABCDE"); load_pat("CD"); load_pat("X");
        go();
        chk("t1_busy_T1", busy, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t1_str", {sme_isstring, sme_ispattern, sme_chardata}, {2'b10, 8'h41 + 8'(k)});
            tick();
        end
        chk("t1_pat_C", {sme_isstring, sme_ispattern, sme_chardata}, {2'b01, 8'h43});
        tick();
        chk("t1_pat_D", {sme_isstring, sme_ispattern, sme_chardata}, {2'b01, 8'h44});
        tick();
        chk("t1_wait_quiet", {busy, sme_isstring, sme_ispattern, res_valid, sme_chardata}, {4'b1000, 8'h00});
        tick();
        sme_valid = 1; sme_match = 1; sme_match_index = 5'd2;
        tick();
        sme_valid = 0; sme_match = 0; sme_match_index = 0;
        chk("t1_res0", {res_valid, res_match, res_index, res_id, res_timeout}, {2'b11, 5'd2, 2'd0, 1'b0});
        tick();
        chk("t1_pat_X", {sme_ispattern, sme_chardata}, {1'b1, 8'h58});
        tick();
        sme_valid = 1; sme_match = 0; sme_match_index = 5'd0;
        tick();
        sme_valid = 0;
        chk("t1_res1", {res_valid, res_match, res_index, res_id, res_timeout}, {2'b10, 5'd0, 2'd1, 1'b0});
        tick();
        chk("t1_done", {done, busy, res_valid}, 3'b100);
        tick();
        chk("t1_idle", {done, busy}, 2'b00);

        // Timeout: engine never answers
        load_str("Q"); load_pat("A");
        go();
        chk("t2_str", {sme_isstring, sme_chardata}, {1'b1, 8'h51});
        tick();
        chk("t2_pat", {sme_ispattern, sme_chardata}, {1'b1, 8'h41});
        n = 0;
        for (int k = 0; k < TMO + 10; k++) begin
            tick(); n++;
            if (res_valid) break;
        end
        chk("t2_tmo_latency", n, TMO + 1);
        chk("t2_tmo_res", {res_valid, res_match, res_index, res_id, res_timeout}, {2'b10, 5'd0, 2'd0, 1'b1});
        tick();
        chk("t2_done", {done, busy}, 2'b10);
        tick();

        // Overflow: 33 string chars and a 9-char pattern; writes/start during busy ignored
        for (int k = 0; k < 33; k++) begin
            wr_en = 1; wr_sel = 0; wr_data = 8'(k);
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            wr_en = 1; wr_sel = 1; wr_last = (k == 8); wr_data = 8'h40 + 8'(k);
            tick();
        end
        wr_en = 0; wr_last = 0;
        chk("t3_ovf_set", ovf, 1);
        go();
        chk("t3_ovf_cleared", ovf, 0);
        nstr = 0; npat = 0; lastp = 0; tmo_seen = 0; saw_done = 0;
        for (int k = 0; k < 400; k++) begin
            if (sme_isstring) nstr++;
            if (sme_ispattern) begin npat++; lastp = sme_chardata; end
            if (res_valid) tmo_seen = res_timeout;
            if (done) begin saw_done = 1; break; end
            if (k == 60) begin wr_en = 1; wr_sel = 0; wr_data = 8'hEE; start = 1; end
            if (k == 61) begin wr_en = 0; start = 0; end
            tick();
        end
        chk("t3_done_seen", saw_done, 1);
        chk("t3_str_count", nstr, 32);
        chk("t3_pat_count", npat, 8);
        chk("t3_last_pat_char", lastp, 8'h47);
        chk("t3_tmo", tmo_seen, 1);
        chk("t3_ovf_busy_write", ovf, 0);
        tick();
        chk("t3_no_restart", {busy, done}, 2'b00);

        // start with no pattern loaded
        load_str("Z");
        go();
        chk("t4_done_T1", {done, busy, sme_isstring, sme_ispattern}, 4'b1000);
        tick();
        chk("t4_idle", {done, busy}, 2'b00);

        // Reset mid-PAT
        load_str("AB"); load_pat("CD");
        go(); tick(); tick();
        chk("t5_in_pat", {sme_ispattern, sme_chardata}, {1'b1, 8'h43});
        reset = 1'b0;
        #1;
        chk("t5_async_drop", {busy, sme_isstring, sme_ispattern, sme_chardata, res_valid, done}, 0);
        tick();
        reset = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 3; k++) begin tick(); if (done) saw_done = 1; end
        chk("t5_no_done", saw_done, 0);
        load_str("AB"); load_pat("B");
        go();
        chk("t5_clean_s0", {sme_isstring, sme_chardata}, {1'b1, 8'h41});
        tick();
        chk("t5_clean_s1", {sme_isstring, sme_chardata}, {1'b1, 8'h42});
        tick();
        chk("t5_clean_p", {sme_ispattern, sme_chardata}, {1'b1, 8'h42});
        tick();
        sme_valid = 1; sme_match = 1; sme_match_index = 5'd1;
        tick();
        sme_valid = 0; sme_match = 0; sme_match_index = 0;
        chk("t5_clean_res", {res_valid, res_match, res_index, res_id, res_timeout}, {2'b11, 5'd1, 2'd0, 1'b0});
        tick();
        chk("t5_clean_done", done, 1);
        tick();

        // Four patterns; stray sme_valid during STR
        pats = "ABCD";
        load_str("ABCD"); load_pat("A"); load_pat("B"); load_pat("C"); load_pat("D");
        go();
        sme_valid = 1; sme_match = 1; sme_match_index = 5'd9;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) sme_valid = 0;
            tick();
        end
        sme_valid = 0; sme_match = 0; sme_match_index = 0;
        for (int p = 0; p < 4; p++) begin
            chk("t6_pat", {sme_ispattern, sme_chardata}, {1'b1, pats[p]});
            tick();
            sme_valid = 1; sme_match = p[0]; sme_match_index = 5'(p + 3);
            tick();
            sme_valid = 0;
            chk("t6_res", {res_valid, res_match, res_index, res_id, res_timeout},
                {1'b1, p[0], 5'(p + 3), 2'(p), 1'b0});
            tick();
        end
        chk("t6_done", {done, busy}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

`default_nettype wire
